// File: rtl/pc_pkg.sv
//------------------------------------------------------------------------------
// Module   : pc_pkg
// Purpose  : Shared command encoding and default constants for pc_stack_seq.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package pc_pkg;

    localparam int C_DEF_ADDR_W      = 8;
    localparam int C_DEF_STACK_DEPTH = 4;
    localparam int C_DEF_OFF_W       = 8;
    localparam int C_DEF_RESET_VEC   = 0;

    typedef enum logic [2:0] {
        CMD_NONE   = 3'd0,
        CMD_LOAD   = 3'd1,
        CMD_CALL   = 3'd2,
        CMD_RET    = 3'd3,
        CMD_BRANCH = 3'd4,
        CMD_INCR   = 3'd5
    } pc_cmd_e;

    // Fixed priority: load > call > ret > branch > incr.
    function automatic pc_cmd_e encode_cmd(
        input logic load_pc,
        input logic call,
        input logic ret,
        input logic branch,
        input logic incr_pc
    );
        if (load_pc)      return CMD_LOAD;
        else if (call)    return CMD_CALL;
        else if (ret)     return CMD_RET;
        else if (branch)  return CMD_BRANCH;
        else if (incr_pc) return CMD_INCR;
        else              return CMD_NONE;
    endfunction

endpackage

`default_nettype wire

// File: rtl/ras_lifo.sv
//------------------------------------------------------------------------------
// Module   : ras_lifo
// Purpose  : Return-address LIFO; ignores push when full and pop when empty.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module ras_lifo #(
    parameter int ADDR_W      = 8,
    parameter int STACK_DEPTH = 4
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               push,
    input  logic                               pop,
    input  logic [ADDR_W-1:0]                  push_data,
    output logic [ADDR_W-1:0]                  top,
    output logic [$clog2(STACK_DEPTH+1)-1:0]   sp,
    output logic                               full,
    output logic                               empty
);

    localparam int C_SP_W = $clog2(STACK_DEPTH+1);

    logic [C_SP_W-1:0] r_sp;
    logic [ADDR_W-1:0] r_mem [STACK_DEPTH];
    logic              w_do_push;
    logic              w_do_pop;

    assign full      = (r_sp == C_SP_W'(STACK_DEPTH));
    assign empty     = (r_sp == '0);
    assign w_do_push = push && !full;
    assign w_do_pop  = pop && !push && !empty;
    assign sp        = r_sp;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sp <= '0;
        end else if (w_do_push) begin
            r_sp <= r_sp + C_SP_W'(1);
        end else if (w_do_pop) begin
            r_sp <= r_sp - C_SP_W'(1);
        end
    end

    // Entry storage carries no reset: contents are meaningless while sp excludes them.
    always_ff @(posedge clk) begin
        for (int i = 0; i < STACK_DEPTH; i++) begin
            if (w_do_push && (r_sp == C_SP_W'(i))) begin
                r_mem[i] <= push_data;
            end
        end
    end

    always_comb begin
        top = '0;
        for (int i = 0; i < STACK_DEPTH; i++) begin
            if (r_sp == C_SP_W'(i + 1)) begin
                top = r_mem[i];
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/pc_stack_seq.sv
//------------------------------------------------------------------------------
// Module   : pc_stack_seq
// Purpose  : Program counter with load/incr/branch and call/return stack.
//            Define PC_STACK_STICKY_ERR_EN for sticky overflow/underflow flags.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module pc_stack_seq
    import pc_pkg::*;
#(
    parameter int ADDR_W      = C_DEF_ADDR_W,
    parameter int STACK_DEPTH = C_DEF_STACK_DEPTH,
    parameter int OFF_W       = C_DEF_OFF_W,
    parameter int RESET_VEC   = C_DEF_RESET_VEC
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               load_pc,
    input  logic                               incr_pc,
    input  logic                               branch,
    input  logic                               call,
    input  logic                               ret,
    input  logic [ADDR_W-1:0]                  addr,
    input  logic [OFF_W-1:0]                   offset,
    output logic [ADDR_W-1:0]                  pc,
    output logic [$clog2(STACK_DEPTH+1)-1:0]   sp,
    output logic                               stack_full,
    output logic                               stack_empty,
    output logic                               overflow,
    output logic                               underflow
);

    pc_cmd_e           w_cmd;
    logic [ADDR_W-1:0] r_pc;
    logic [ADDR_W-1:0] w_pc_next;
    logic [ADDR_W-1:0] w_pc_inc;
    logic [ADDR_W-1:0] w_off_ext;
    logic [ADDR_W-1:0] w_top;
    logic              w_push;
    logic              w_pop;
    logic              w_ovf_evt;
    logic              w_unf_evt;
    logic              r_ovf;
    logic              r_unf;

    assign w_cmd    = encode_cmd(load_pc, call, ret, branch, incr_pc);
    assign w_pc_inc = r_pc + ADDR_W'(1);

    if (OFF_W < ADDR_W) begin : g_sext
        assign w_off_ext = {{(ADDR_W-OFF_W){offset[OFF_W-1]}}, offset};
    end else begin : g_same
        assign w_off_ext = offset;
    end

    ras_lifo #(
        .ADDR_W      (ADDR_W),
        .STACK_DEPTH (STACK_DEPTH)
    ) u_ras (
        .clk       (clk),
        .reset     (reset),
        .push      (w_push),
        .pop       (w_pop),
        .push_data (w_pc_inc),
        .top       (w_top),
        .sp        (sp),
        .full      (stack_full),
        .empty     (stack_empty)
    );

    always_comb begin
        w_pc_next = r_pc;
        w_push    = 1'b0;
        w_pop     = 1'b0;
        w_ovf_evt = 1'b0;
        w_unf_evt = 1'b0;
        case (w_cmd)
            CMD_LOAD:   w_pc_next = addr;
            CMD_CALL: begin
                if (stack_full) begin
                    w_ovf_evt = 1'b1;
                end else begin
                    w_push    = 1'b1;
                    w_pc_next = addr;
                end
            end
            CMD_RET: begin
                if (stack_empty) begin
                    w_unf_evt = 1'b1;
                end else begin
                    w_pop     = 1'b1;
                    w_pc_next = w_top;
                end
            end
            CMD_BRANCH: w_pc_next = r_pc + w_off_ext;
            CMD_INCR:   w_pc_next = w_pc_inc;
            default:    w_pc_next = r_pc;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pc  <= ADDR_W'(RESET_VEC);
            r_ovf <= 1'b0;
            r_unf <= 1'b0;
        end else begin
            r_pc  <= w_pc_next;
`ifdef PC_STACK_STICKY_ERR_EN
            r_ovf <= r_ovf | w_ovf_evt;
            r_unf <= r_unf | w_unf_evt;
`else
            r_ovf <= w_ovf_evt;
            r_unf <= w_unf_evt;
`endif
        end
    end

    assign pc        = r_pc;
    assign overflow  = r_ovf;
    assign underflow = r_unf;

endmodule

`default_nettype wire

// File: tb/tb_pc_stack_seq.sv
//------------------------------------------------------------------------------
// Module   : tb_pc_stack_seq
// Purpose  : Self-checking bench: directed vector table, reset corner, random.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_pc_stack_seq;

`ifdef PC_STACK_STICKY_ERR_EN
    localparam bit C_STICKY = 1'b1;
`else
    localparam bit C_STICKY = 1'b0;
`endif
    localparam int C_DEPTH = 4;

    // Command mask bit order: {load_pc, call, ret, branch, incr_pc}
    localparam logic [4:0] C_L = 5'b10000;
    localparam logic [4:0] C_C = 5'b01000;
    localparam logic [4:0] C_R = 5'b00100;
    localparam logic [4:0] C_B = 5'b00010;
    localparam logic [4:0] C_I = 5'b00001;
    localparam logic [4:0] C_N = 5'b00000;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       load_pc = 1'b0, incr_pc = 1'b0, branch = 1'b0, call = 1'b0, ret = 1'b0;
    logic [7:0] addr = '0, offset = '0;
    logic [7:0] pc;
    logic [2:0] sp;
    logic       stack_full, stack_empty, overflow, underflow;

    int n_vec = 0;
    int n_bad = 0;

    // Reference model state
    int m_pc;
    int m_stk[$];
    bit m_ovf, m_unf;

    pc_stack_seq dut (
        .clk(clk), .reset(reset), .load_pc(load_pc), .incr_pc(incr_pc),
        .branch(branch), .call(call), .ret(ret), .addr(addr), .offset(offset),
        .pc(pc), .sp(sp), .stack_full(stack_full), .stack_empty(stack_empty),
        .overflow(overflow), .underflow(underflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0] cmd;
        logic [7:0] a;
        logic [7:0] o;
        int         pc;
        int         sp;
        bit         ovf;
        bit         unf;
    } vec_t;

    vec_t tbl[34];

    function automatic vec_t mk(input logic [4:0] c, input logic [7:0] a, input logic [7:0] o,
                                input int p, input int s, input bit ov, input bit un);
        vec_t v;
        v.cmd = c; v.a = a; v.o = o; v.pc = p; v.sp = s; v.ovf = ov; v.unf = un;
        return v;
    endfunction

    task automatic check(input string name, input int epc, input int esp, input bit eovf, input bit eunf);
        logic [14:0] act, exp;
        act = {pc, sp, stack_full, stack_empty, overflow, underflow};
        exp = {epc[7:0], esp[2:0], (esp == C_DEPTH), (esp == 0), eovf, eunf};
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got pc=%02h sp=%0d full=%b empty=%b ovf=%b unf=%b, want pc=%02h sp=%0d full=%b empty=%b ovf=%b unf=%b",
                     name, pc, sp, stack_full, stack_empty, overflow, underflow,
                     epc[7:0], esp, (esp == C_DEPTH), (esp == 0), eovf, eunf);
        end
    endtask

    task automatic apply(input logic [4:0] c, input logic [7:0] a, input logic [7:0] o);
        {load_pc, call, ret, branch, incr_pc} = c;
        addr = a;
        offset = o;
        @(posedge clk);
        #1;
        {load_pc, call, ret, branch, incr_pc} = '0;
    endtask

    task automatic model_reset();
        m_pc = 0;
        m_stk.delete();
        m_ovf = 1'b0;
        m_unf = 1'b0;
    endtask

    task automatic model_step(input logic [4:0] c, input logic [7:0] a, input logic [7:0] o);
        bit ov, un;
        ov = 1'b0;
        un = 1'b0;
        if (c[4]) begin
            m_pc = int'(a);
        end else if (c[3]) begin
            if (m_stk.size() == C_DEPTH) ov = 1'b1;
            else begin
                m_stk.push_back((m_pc + 1) % 256);
                m_pc = int'(a);
            end
        end else if (c[2]) begin
            if (m_stk.size() == 0) un = 1'b1;
            else m_pc = m_stk.pop_back();
        end else if (c[1]) begin
            m_pc = (m_pc + int'($signed(o)) + 256) % 256;
        end else if (c[0]) begin
            m_pc = (m_pc + 1) % 256;
        end
        m_ovf = C_STICKY ? (m_ovf | ov) : ov;
        m_unf = C_STICKY ? (m_unf | un) : un;
    endtask

    initial begin
        bit acc_ovf, acc_unf;
        logic [4:0] c;
        logic [7:0] a, o;

        tbl[0]  = mk(C_I,           8'h00, 8'h00, 8'h01, 0, 0, 0);
        tbl[1]  = mk(C_I,           8'h00, 8'h00, 8'h02, 0, 0, 0);
        tbl[2]  = mk(C_I,           8'h00, 8'h00, 8'h03, 0, 0, 0);
        tbl[3]  = mk(C_L,           8'h10, 8'h00, 8'h10, 0, 0, 0);
        tbl[4]  = mk(C_B,           8'h00, 8'hFC, 8'h0C, 0, 0, 0);
        tbl[5]  = mk(C_B,           8'h00, 8'h7F, 8'h8B, 0, 0, 0);
        tbl[6]  = mk(C_L,           8'h02, 8'h00, 8'h02, 0, 0, 0);
        tbl[7]  = mk(C_B,           8'h00, 8'hFC, 8'hFE, 0, 0, 0);
        tbl[8]  = mk(C_I,           8'h00, 8'h00, 8'hFF, 0, 0, 0);
        tbl[9]  = mk(C_I,           8'h00, 8'h00, 8'h00, 0, 0, 0);
        tbl[10] = mk(C_B,           8'h00, 8'h00, 8'h00, 0, 0, 0);
        tbl[11] = mk(C_L,           8'h20, 8'h00, 8'h20, 0, 0, 0);
        tbl[12] = mk(C_C,           8'h80, 8'h00, 8'h80, 1, 0, 0);
        tbl[13] = mk(C_I,           8'h00, 8'h00, 8'h81, 1, 0, 0);
        tbl[14] = mk(C_R,           8'h00, 8'h00, 8'h21, 0, 0, 0);
        tbl[15] = mk(C_L,           8'h00, 8'h00, 8'h00, 0, 0, 0);
        tbl[16] = mk(C_C,           8'h10, 8'h00, 8'h10, 1, 0, 0);
        tbl[17] = mk(C_C,           8'h20, 8'h00, 8'h20, 2, 0, 0);
        tbl[18] = mk(C_C,           8'h30, 8'h00, 8'h30, 3, 0, 0);
        tbl[19] = mk(C_C,           8'h40, 8'h00, 8'h40, 4, 0, 0);
        tbl[20] = mk(C_C,           8'h50, 8'h00, 8'h40, 4, 1, 0);
        tbl[21] = mk(C_R,           8'h00, 8'h00, 8'h31, 3, 0, 0);
        tbl[22] = mk(C_R,           8'h00, 8'h00, 8'h21, 2, 0, 0);
        tbl[23] = mk(C_R,           8'h00, 8'h00, 8'h11, 1, 0, 0);
        tbl[24] = mk(C_R,           8'h00, 8'h00, 8'h01, 0, 0, 0);
        tbl[25] = mk(C_R,           8'h00, 8'h00, 8'h01, 0, 0, 1);
        tbl[26] = mk(C_I,           8'h00, 8'h00, 8'h02, 0, 0, 0);
        tbl[27] = mk(C_L | C_C | C_I, 8'h55, 8'h00, 8'h55, 0, 0, 0);
        tbl[28] = mk(C_C,           8'h60, 8'h00, 8'h60, 1, 0, 0);
        tbl[29] = mk(C_C | C_R,     8'h70, 8'h00, 8'h70, 2, 0, 0);
        tbl[30] = mk(C_R,           8'h00, 8'h00, 8'h61, 1, 0, 0);
        tbl[31] = mk(C_R | C_B | C_I, 8'h00, 8'h05, 8'h56, 0, 0, 0);
        tbl[32] = mk(C_R | C_I,     8'h00, 8'h00, 8'h56, 0, 0, 1);
        tbl[33] = mk(C_N,           8'h00, 8'h00, 8'h56, 0, 0, 0);

        // Reset state
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("reset", 0, 0, 0, 0);
        reset = 1'b0;

        // Directed table; sticky mode accumulates the per-step pulse expectations
        acc_ovf = 1'b0;
        acc_unf = 1'b0;
        for (int i = 0; i < 34; i++) begin
            apply(tbl[i].cmd, tbl[i].a, tbl[i].o);
            acc_ovf |= tbl[i].ovf;
            acc_unf |= tbl[i].unf;
            check($sformatf("tbl[%0d]", i), tbl[i].pc, tbl[i].sp,
                  C_STICKY ? acc_ovf : tbl[i].ovf, C_STICKY ? acc_unf : tbl[i].unf);
        end

        // Asynchronous reset mid call sequence, observed before the next edge
        apply(C_L, 8'h00, 8'h00);
        apply(C_C, 8'hA0, 8'h00);
        apply(C_C, 8'hB0, 8'h00);
        check("pre_reset", 8'hB0, 2, C_STICKY ? acc_ovf : 1'b0, C_STICKY ? acc_unf : 1'b0);
        #2;
        {load_pc, call, ret, branch, incr_pc} = C_C | C_I;
        addr = 8'hC0;
        reset = 1'b1;
        #1;
        check("async_reset", 0, 0, 0, 0);
        @(posedge clk);
        #1;
        check("reset_hold", 0, 0, 0, 0);
        {load_pc, call, ret, branch, incr_pc} = '0;
        reset = 1'b0;

        // Randomised run against the reference model
        model_reset();
        for (int n = 0; n < 600; n++) begin
            c[4] = ($urandom_range(0, 99) < 8);
            c[3] = ($urandom_range(0, 99) < 30);
            c[2] = ($urandom_range(0, 99) < 30);
            c[1] = ($urandom_range(0, 99) < 20);
            c[0] = ($urandom_range(0, 99) < 30);
            a = 8'($urandom);
            o = 8'($urandom);
            if (n % 150 == 149) begin
                #2;
                reset = 1'b1;
                model_reset();
                #1;
                check($sformatf("rnd_reset[%0d]", n), m_pc, m_stk.size(), m_ovf, m_unf);
                @(posedge clk);
                #1;
                reset = 1'b0;
            end else begin
                apply(c, a, o);
                model_step(c, a, o);
                check($sformatf("rnd[%0d]", n), m_pc, m_stk.size(), m_ovf, m_unf);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
